// File: rtl/mul_pkg.sv
// Shared types for the Booth multiplier front end.
// Operand encodings, widths and the Booth select decode.
package mul_pkg;

  localparam int XLEN   = 32;
  localparam int MUL_N  = 68;
  localparam int PP_NUM = 17;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    BS_ZERO,
    BS_POS1,
    BS_POS2,
    BS_NEG1,
    BS_NEG2
  } booth_sel_e;

  // Radix-4 recode of {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_sel_e booth_decode(
    input logic [2:0] grp
  );
    booth_sel_e sel;
    unique case (grp)
      3'b001, 3'b010: sel = BS_POS1;
      3'b011:         sel = BS_POS2;
      3'b100:         sel = BS_NEG2;
      3'b101, 3'b110: sel = BS_NEG1;
      default:        sel = BS_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// One Booth group: picks 0, +-A or +-2A, sign-extended to N bits.
// Negatives are one's complement; the +1 goes in sign_comp.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int AW = XLEN + 1,
  parameter int N  = MUL_N
) (
  input  logic [2:0]    i_grp,
  input  logic [AW-1:0] i_a,
  output logic [N-1:0]  o_pp,
  output logic          o_neg
);

  booth_sel_e   w_sel;
  logic [N-1:0] w_a1;
  logic [N-1:0] w_a2;

  assign w_sel = booth_decode(i_grp);
  assign w_a1  = {{(N-AW){i_a[AW-1]}}, i_a};
  assign w_a2  = {w_a1[N-2:0], 1'b0};

  // select the multiple; zero group yields no negation flag
  always_comb begin
    o_pp  = '0;
    o_neg = 1'b0;
    unique case (w_sel)
      BS_POS1: o_pp = w_a1;
      BS_POS2: o_pp = w_a2;
      BS_NEG1: begin
        o_pp  = ~w_a1;
        o_neg = 1'b1;
      end
      BS_NEG2: begin
        o_pp  = ~w_a2;
        o_neg = 1'b1;
      end
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_pp_gen.sv
// Radix-4 Booth partial-product generator, two register stages.
// S1 captures extended operands, S2 holds decoded pp + comp.
module mul_booth_pp_gen #(
  parameter int XLEN   = mul_pkg::XLEN,
  parameter int N      = mul_pkg::MUL_N,
  parameter int PP_NUM = mul_pkg::PP_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [XLEN-1:0]       in_rs1,
  input  logic [XLEN-1:0]       in_rs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_op,
  output logic [PP_NUM*N-1:0]   out_pp,
  output logic [N-1:0]          out_sign_comp
);

  import mul_pkg::*;

  localparam int BW = XLEN + 2;

  if (PP_NUM != (XLEN + 2) / 2 || N < 2 * XLEN + 2) begin : g_bad_cfg
    $error("mul_booth_pp_gen: bad PP_NUM/N for XLEN");
  end

  logic                r_s1_valid;
  logic [XLEN:0]       r_a;
  logic [BW-1:0]       r_b;
  logic [1:0]          r_op;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_accept;
  logic                w_sa;
  logic                w_sb;
  logic [BW:0]         w_bx;
  logic [N-1:0]        w_raw [PP_NUM];
  logic [PP_NUM-1:0]   w_neg;
  logic [PP_NUM*N-1:0] w_pp;
  logic [N-1:0]        w_comp;

  assign w_s2_adv = !out_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = !r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  assign w_sa = (in_op != MUL_OP_MULHU);
  assign w_sb = (in_op == MUL_OP_MUL) | (in_op == MUL_OP_MULH);

  assign w_bx = {r_b, 1'b0};

  for (genvar gi = 0; gi < PP_NUM; gi++) begin : g_pp
    booth_pp_sel #(
      .AW (XLEN + 1),
      .N  (N)
    ) u_sel (
      .i_grp (w_bx[2*gi +: 3]),
      .i_a   (r_a),
      .o_pp  (w_raw[gi]),
      .o_neg (w_neg[gi])
    );
    assign w_pp[gi*N +: N] = w_raw[gi] << (2 * gi);
  end

  // one correction bit at the LSB weight of each negative group
  always_comb begin
    w_comp = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      w_comp[2*i] = w_neg[i];
    end
  end

  // S1 occupancy; flush wins over a same-cycle accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S1 operand capture with sign extension per op
  always_ff @(posedge clk) begin
    if (w_accept && !flush) begin
      r_a  <= {in_rs1[XLEN-1] & w_sa, in_rs1};
      r_b  <= {{2{in_rs2[XLEN-1] & w_sb}}, in_rs2};
      r_op <= in_op;
    end
  end

  // S2 output register; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pp        <= '0;
      out_sign_comp <= '0;
      out_op        <= MUL_OP_MUL;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_pp        <= w_pp;
        out_sign_comp <= w_comp;
        out_op        <= r_op;
      end
    end
  end

endmodule

// File: tb/tb_mul_booth_pp_gen.sv
// Bench for mul_booth_pp_gen: arithmetic Booth model,
// directed handshake cases and a randomized sweep.
module tb_mul_booth_pp_gen;
  import mul_pkg::*;

  localparam int N = MUL_N;
  localparam int W = PP_NUM * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [31:0]  in_rs1;
  logic [31:0]  in_rs2;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_op;
  logic [W-1:0] out_pp;
  logic [N-1:0] out_sign_comp;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int idle     = 0;
  bit hold_prev = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } txn_t;

  txn_t q[$];

  mul_booth_pp_gen dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_pp        (out_pp),
    .out_sign_comp (out_sign_comp)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ext(
    input logic [31:0] v,
    input bit s
  );
    return {{(N-32){s & v[31]}}, v};
  endfunction

  // pp_i = d_i * A * 4^i, d_i in -2..2; negatives as ~(|d|*A)
  function automatic void model(
    input  txn_t t,
    output logic [W-1:0] pp,
    output logic [N-1:0] comp,
    output logic [N-1:0] prod
  );
    logic [N-1:0] a_v;
    logic [N-1:0] b_v;
    logic [N:0]   bx;
    logic [N-1:0] mag;
    logic [N-1:0] v;
    int d;
    a_v = ext(t.a, t.op != 2'b11);
    b_v = ext(t.b, t.op == 2'b00 || t.op == 2'b01);
    prod = a_v * b_v;
    bx = {b_v, 1'b0};
    pp = '0;
    comp = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      d = int'(bx[2*i]) + int'(bx[2*i+1])
        - 2 * int'(bx[2*i+2]);
      mag = a_v * N'(d < 0 ? -d : d);
      v = (d < 0) ? ~mag : mag;
      pp[i*N +: N] = v << (2 * i);
      if (d < 0) comp[2*i] = 1'b1;
    end
  endfunction

  function automatic logic [N-1:0] sum_pp(
    input logic [W-1:0] pp,
    input logic [N-1:0] comp
  );
    logic [N-1:0] s;
    s = comp;
    for (int i = 0; i < PP_NUM; i++) s += pp[i*N +: N];
    return s;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFF_FFFF,
          32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  task automatic chk(
    input string name,
    input logic [N-1:0] got,
    input logic [N-1:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got,
                      input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // scoreboard: queue holds work in flight, front is in S2
  always @(negedge clk) begin
    logic [W-1:0] epp;
    logic [N-1:0] ec;
    logic [N-1:0] ep;
    int first;
    if (rst || flush) begin
      q.delete();
      hold_prev = 1'b0;
      idle = 0;
    end else begin
      if (hold_prev) chk1("stall_hold_valid", out_valid, 1'b1);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid got=1 exp=0");
        end else begin
          model(q[0], epp, ec, ep);
          checks++;
          if (out_pp !== epp) begin
            failures++;
            first = 0;
            for (int i = PP_NUM - 1; i >= 0; i--)
              if (out_pp[i*N +: N] !== epp[i*N +: N]) first = i;
            $display("FAIL pp[%0d] got=%h exp=%h", first,
                     out_pp[first*N +: N], epp[first*N +: N]);
          end
          chk("sign_comp", out_sign_comp, ec);
          chk("out_op", N'(out_op), N'(q[0].op));
          chk("invariant",
              sum_pp(out_pp, out_sign_comp), ep);
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          idle = 0;
        end
      end
      hold_prev = out_valid && !out_ready;
      if (q.size() > 0) begin
        idle++;
        if (idle == 200) begin
          checks++;
          failures++;
          $display("FAIL drain_timeout got=stuck exp=progress");
        end
      end else begin
        idle = 0;
      end
      if (in_valid && in_ready) begin
        q.push_back('{op: in_op, a: in_rs1, b: in_rs2});
        n_acc++;
      end
    end
  end

  // call at posedge+1; returns at posedge+1 after accept
  task automatic send(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_rs1 = a;
    in_rs2 = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=blocked exp=ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [W-1:0] pp,
                         output logic [N-1:0] comp);
    int n;
    n = 0;
    send(op, a, b);
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("run_one_valid", out_valid, 1'b1);
    pp = out_pp;
    comp = out_sign_comp;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_done", out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pp;
    logic [N-1:0] comp;
    logic [N-1:0] s;
    logic [N-1:0] ten;
    int n0;
    int cyc;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_op = 2'b00;
    in_rs1 = '0;
    in_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_pp_zero", out_pp == '0, 1'b1);
    chk("rst_comp", out_sign_comp, '0);
    chk("rst_op", N'(out_op), N'(0));
    chk1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    run_one(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pp, comp);
    s = sum_pp(pp, comp);
    chk("mulhu_ff", N'(s[63:0]), N'(64'hFFFF_FFFE_0000_0001));

    run_one(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, pp, comp);
    s = sum_pp(pp, comp);
    chk("mulh_min", N'(s[63:0]), N'(64'h4000_0000_0000_0000));

    run_one(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pp, comp);
    s = sum_pp(pp, comp);
    chk("mulhsu_ff", N'(s[63:0]), N'(64'hFFFF_FFFF_0000_0001));

    run_one(MUL_OP_MUL, 32'd5, 32'd2, pp, comp);
    ten = N'(10);
    chk("mul2_pp0_neg2a", pp[0 +: N], ~ten);
    chk("mul2_pp1_pos1a", pp[N +: N], N'(20));
    chk("mul2_comp", comp, N'(1));

    // backpressure: two accepts fill S1/S2, then in_ready drops
    out_ready = 1'b0;
    send(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    send(2'b01, 32'hDEAD_BEEF, 32'h0000_0003);
    in_valid = 1'b1;
    in_op = 2'b10;
    in_rs1 = 32'h8000_0001;
    in_rs2 = 32'hFFFF_FFFE;
    repeat (3) begin
      @(negedge clk);
      chk1("bp_in_ready_low", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b10, 32'h8000_0001, 32'hFFFF_FFFE);
    send(2'b11, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_drain();

    // flush with S1 and S2 full and a fresh input presented
    out_ready = 1'b0;
    send(2'b00, 32'h1111_1111, 32'h2222_2222);
    send(2'b01, 32'h3333_3333, 32'h4444_4444);
    in_valid = 1'b1;
    in_op = 2'b10;
    in_rs1 = 32'h5555_5555;
    in_rs2 = 32'h6666_6666;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b11, 32'hCAFE_F00D, 32'h0BAD_F00D);
    @(negedge clk);
    chk1("lat_edge1_invalid", out_valid, 1'b0);
    @(negedge clk);
    chk1("lat_edge2_valid", out_valid, 1'b1);
    chk("lat_edge2_op", N'(out_op), N'(2'b11));
    @(posedge clk);
    #1;
    wait_drain();

    // reset during a stall drops everything in flight
    out_ready = 1'b0;
    send(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
    send(2'b01, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_stall_valid", out_valid, 1'b0);
    chk1("rst_stall_pp", out_pp == '0, 1'b1);
    chk("rst_stall_comp", out_sign_comp, '0);
    chk1("rst_stall_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_one(MUL_OP_MUL, 32'd7, 32'hFFFF_FFFD, pp, comp);
    s = sum_pp(pp, comp);
    chk("post_rst_mul", N'(s[63:0]), N'(64'hFFFF_FFFF_FFFF_FFEB));

    // randomized sweep with random stalls and rare flushes
    n0 = n_acc;
    cyc = 0;
    while (n_acc - n0 < 10000 && cyc < 60000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 9) < 8);
      in_op = 2'($urandom);
      in_rs1 = pick();
      in_rs2 = pick();
      cyc++;
    end
    chk1("rand_op_count", (n_acc - n0) >= 10000, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
